// File: rtl/modmul_pkg.sv
// Shared types and helpers for the interleaved modular multiplier.
package modmul_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Widest operand the shared subtract helper supports; callers cast down to LEN+1.
  localparam int MAX_LEN = 64;
  typedef logic [MAX_LEN:0] wide_t;

  function automatic int cnt_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

  function automatic wide_t cond_sub(input wide_t x, input wide_t m);
    return (x >= m) ? (x - m) : x;
  endfunction

endpackage

// File: rtl/Counter.sv
// Bit index counter: 0..MAX-1 while cen is high, at_max flags the last index.
module Counter
  import modmul_pkg::*;
#(
  parameter int MAX = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic cen,
  output logic at_max
);

  localparam int W = cnt_width(MAX);
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] count_r;

  assign at_max = (count_r == LAST);

  // Index register, wraps to zero after the last index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (cen) begin
      count_r <= at_max ? {W{1'b0}} : (count_r + W'(1));
    end
  end

endmodule

// File: rtl/modmul_step.sv
// One interleaved iteration: R' = ((2R mod M) + bit*A) mod M, all at LEN+1 bits.
module modmul_step
  import modmul_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic [LEN:0]   r,
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] m,
  input  logic           b_bit,
  output logic [LEN:0]   r_next
);

  logic [LEN:0] dbl_s;
  logic [LEN:0] sub1_s;
  logic [LEN:0] add_s;

  // Double, reduce, conditionally add A, reduce again
  always_comb begin
    dbl_s  = r << 1;
    sub1_s = (LEN+1)'(cond_sub(wide_t'(dbl_s), wide_t'(m)));
    if (b_bit) begin
      add_s = sub1_s + {1'b0, a};
    end else begin
      add_s = sub1_s;
    end
    r_next = (LEN+1)'(cond_sub(wide_t'(add_s), wide_t'(m)));
  end

endmodule

// File: rtl/sh_reg.sv
// Left-shifting parallel-load register exposing its MSB; ld has priority over clr.
module sh_reg #(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           ld,
  input  logic           shl,
  input  logic [LEN-1:0] d,
  output logic           msb
);

  logic [LEN-1:0] q_r;

  assign msb = q_r[LEN-1];

  // Shift register storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= {LEN{1'b0}};
    end else if (ld) begin
      q_r <= d;
    end else if (clr) begin
      q_r <= {LEN{1'b0}};
    end else if (shl) begin
      q_r <= {q_r[LEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/interleaved_modmul.sv
// Bit-serial interleaved modular multiplier: result = (a*b) mod m, MSB of b first.
// Define MODMUL_ERR_CHECK_EN to add the err output and the a<m, m!=0 precondition check.
module interleaved_modmul
  import modmul_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] b,
  input  logic [LEN-1:0] m,
  output logic           busy,
  output logic           done,
  output logic [LEN-1:0] result
`ifdef MODMUL_ERR_CHECK_EN
  ,
  output logic           err
`endif
);

  state_t         state_r, state_s;
  logic [LEN-1:0] a_r, m_r;
  logic [LEN:0]   r_r, r_next_s;
  logic           busy_s, done_s;
  logic           start_accept_s, bad_s, run_s, clr_s, b_msb_s, at_max_s;

  // busy/done are registered, so the visible DONE cycle is the one where start must be ignored
  assign start_accept_s = start && (state_r == S_IDLE) && !busy && !rst;
  assign run_s          = (state_r == S_RUN);
  assign clr_s          = rst || start_accept_s;

`ifdef MODMUL_ERR_CHECK_EN
  assign bad_s = (m == {LEN{1'b0}}) || (a >= m);

  // err reflects the precondition check of the most recently accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (start_accept_s) begin
      err <= bad_s;
    end
  end
`else
  assign bad_s = 1'b0;
`endif

  // State and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= busy_s;
      done    <= done_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_accept_s) begin
          state_s = bad_s ? S_DONE : S_RUN;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (at_max_s) begin
          state_s = S_DONE;
        end else begin
          state_s = S_RUN;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Status decode, registered one cycle later
  always_comb begin
    busy_s = (state_r != S_IDLE);
    done_s = (state_r == S_DONE);
  end

  // Operand latches, accumulator and result
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= {LEN{1'b0}};
      m_r    <= {LEN{1'b0}};
      r_r    <= {(LEN+1){1'b0}};
      result <= {LEN{1'b0}};
    end else begin
      if (start_accept_s) begin
        a_r <= a;
        m_r <= m;
        r_r <= {(LEN+1){1'b0}};
      end else if (run_s) begin
        r_r <= r_next_s;
      end
      if (state_r == S_DONE) begin
        result <= r_r[LEN-1:0];
      end
    end
  end

  modmul_step #(.LEN(LEN)) u_step (
    .r      (r_r),
    .a      (a_r),
    .m      (m_r),
    .b_bit  (b_msb_s),
    .r_next (r_next_s)
  );

  sh_reg #(.LEN(LEN)) u_bsh (
    .clk (clk),
    .rst (1'b0),
    .clr (clr_s),
    .ld  (start_accept_s),
    .shl (run_s),
    .d   (b),
    .msb (b_msb_s)
  );

  Counter #(.MAX(LEN)) u_cnt (
    .clk    (clk),
    .rst    (1'b0),
    .clr    (clr_s),
    .cen    (run_s),
    .at_max (at_max_s)
  );

endmodule

// File: tb/tb_interleaved_modmul.sv
// Self-checking bench for interleaved_modmul (LEN=8): timing/result model plus directed vectors.
module tb_interleaved_modmul;
  localparam int LEN = 8;

  logic           clk = 1'b0;
  logic           rst, start;
  logic [LEN-1:0] a, b, m;
  logic           busy, done;
  logic [LEN-1:0] result;
`ifdef MODMUL_ERR_CHECK_EN
  logic           err;
`endif

  interleaved_modmul #(.LEN(LEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .m      (m),
    .busy   (busy),
    .done   (done),
    .result (result)
`ifdef MODMUL_ERR_CHECK_EN
    ,
    .err    (err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: cycle index, accept edge, done cycle, pending and visible results
  int             cyc       = 0;
  bit             m_active  = 1'b0;
  int             m_acc     = 0;
  int             m_done_at = 0;
  logic [LEN-1:0] m_pend    = '0;
  logic [LEN-1:0] m_result  = '0;
  bit             m_err     = 1'b0;

  function automatic logic [LEN-1:0] ref_mod(input logic [LEN-1:0] x, y, mm);
    longint unsigned xl, yl, ml;
    xl = x; yl = y; ml = mm;
    if (ml == 0) return '0;
    return LEN'((xl * yl) % ml);
  endfunction

  function automatic bit is_bad(input logic [LEN-1:0] x, mm);
`ifdef MODMUL_ERR_CHECK_EN
    return (mm == 0) || (x >= mm);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A start is taken only if driven in a cycle after the previous op's done cycle
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_active <= 1'b0;
      m_result <= '0;
      m_err    <= 1'b0;
    end else begin
      if (m_active && (cyc + 1 == m_done_at)) m_result <= m_pend;
      if (start && !(m_active && cyc <= m_done_at)) begin
        m_active  <= 1'b1;
        m_acc     <= cyc + 1;
        m_done_at <= is_bad(a, m) ? cyc + 2 : cyc + LEN + 2;
        m_pend    <= is_bad(a, m) ? '0 : ref_mod(a, b, m);
        m_err     <= is_bad(a, m);
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("busy", busy, (m_active && cyc > m_acc && cyc <= m_done_at));
      check("done", done, (m_active && cyc == m_done_at));
      check("result_model", result, m_result);
`ifdef MODMUL_ERR_CHECK_EN
      check("err", err, m_err);
`endif
    end
  end

  task automatic pulse_start(input logic [LEN-1:0] ia, ib, im);
    @(negedge clk);
    a = ia; b = ib; m = im; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ia; b = ~ib; m = ~im;
  endtask

  task automatic wait_done(output int lat, output int busy_n, output bit seen);
    lat = 0; busy_n = 0; seen = 1'b0;
    while (!seen && lat < LEN + 10) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic run_op(input logic [LEN-1:0] ia, ib, im, exp, input bit pin);
    int lat, bn;
    bit seen;
    if (pin) check("model_pin", ref_mod(ia, ib, im), exp);
    pulse_start(ia, ib, im);
    wait_done(lat, bn, seen);
    check("done_seen", seen, 1);
    check("latency", lat, LEN + 1);
    check("busy_cycles", bn, LEN + 1);
    check("result", result, exp);
  endtask

  task automatic count_dones(input int ncyc, output int nd);
    nd = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int             nd, lat, bn;
    bit             seen;
    logic [LEN-1:0] ra, rb, rm;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; m = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);

    run_op(8'd5, 8'd7, 8'd11, 8'd2, 1'b1);
    run_op(8'd10, 8'd255, 8'd251, 8'd40, 1'b1);
    run_op(8'd254, 8'd254, 8'd255, 8'd1, 1'b1);
    run_op(8'd0, 8'd200, 8'd13, 8'd0, 1'b1);
    run_op(8'd3, 8'd4, 8'd7, 8'd5, 1'b1);

    // start held during the done cycle is ignored
    a = 8'd6; b = 8'd6; m = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_dones(LEN + 4, nd);
    check("done_cycle_start_ignored", nd, 0);
    check("done_cycle_result_kept", result, 5);

    // start during RUN is ignored
    pulse_start(8'd9, 8'd9, 8'd10);
    repeat (3) @(negedge clk);
    a = 8'd1; b = 8'd1; m = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bn, seen);
    check("run_start_done_seen", seen, 1);
    check("run_start_result", result, 1);
    count_dones(LEN + 4, nd);
    check("run_start_no_extra_done", nd, 0);

    // reset in the middle of RUN
    pulse_start(8'd9, 8'd8, 8'd10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_done", done, 0);
    check("midrun_rst_result", result, 0);
    run_op(8'd6, 8'd6, 8'd7, 8'd1, 1'b1);

    run_op(8'd200, 8'd255, 8'd201, 8'd147, 1'b1);
    run_op(8'd0, 8'd77, 8'd1, 8'd0, 1'b1);
    run_op(8'd254, 8'd255, 8'd255, 8'd0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      rm = LEN'($urandom_range(1, 255));
      ra = LEN'($urandom_range(0, int'(rm) - 1));
      rb = LEN'($urandom_range(0, 255));
      run_op(ra, rb, rm, ref_mod(ra, rb, rm), 1'b0);
    end

`ifdef MODMUL_ERR_CHECK_EN
    pulse_start(8'd12, 8'd5, 8'd11);
    wait_done(lat, bn, seen);
    check("errchk_seen", seen, 1);
    check("errchk_latency", lat, 1);
    check("errchk_err", err, 1);
    check("errchk_result", result, 0);
    pulse_start(8'd5, 8'd5, 8'd0);
    wait_done(lat, bn, seen);
    check("errchk_m0_err", err, 1);
    run_op(8'd3, 8'd4, 8'd7, 8'd5, 1'b1);
    check("errchk_cleared", err, 0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
